// File: rtl/sha_nonce_scheduler.sv
// rtl/sha_nonce_scheduler.sv - nonce job scheduler feeding one SHA-256 core
// Ports:
//   clk, rst (async, active-low)
//   job_valid/job_ready, job_header[607:0], job_target[255:0], job_nonce_end[31:0] : job intake
//   abort                                                                      : cancel current job
//   core_start, core_message[1023:0], core_done, core_digest[255:0]             : core handshake
//   found_valid, found_nonce[31:0], found_digest[255:0], found_ack              : hit report
//   exhausted, timeout_err, hash_count[31:0]                                    : status
module sha_nonce_scheduler #(
    parameter logic [31:0] NONCE_START    = 32'd0,
    parameter logic [31:0] NONCE_STEP     = 32'd1,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [607:0]  job_header,
    input  logic [255:0]  job_target,
    input  logic [31:0]   job_nonce_end,
    input  logic          abort,
    output logic          core_start,
    output logic [1023:0] core_message,
    input  logic          core_done,
    input  logic [255:0]  core_digest,
    output logic          found_valid,
    output logic [31:0]   found_nonce,
    output logic [255:0]  found_digest,
    input  logic          found_ack,
    output logic          exhausted,
    output logic          timeout_err,
    output logic [31:0]   hash_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_REPORT,
        ST_NEXT
    } state_t;

    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [255:0]  target_q;
    logic [255:0]  digest_q;
    logic [31:0]   nonce_end_q;
    logic [31:0]   nonce_q;
    logic [31:0]   watchdog;
    logic [31:0]   nonce_rem;
    logic [31:0]   nonce_nxt;

    // Distance to the inclusive end nonce, modulo 2^32, so ranges that
    // wrap through 0xFFFFFFFF terminate correctly.
    assign nonce_rem = nonce_end_q - nonce_q;
    assign nonce_nxt = nonce_q + NONCE_STEP;

    // Second SHA block is fixed padding: pad bit after the nonce and a
    // 640-bit message length in the last 64 bits.
    function automatic logic [1023:0] build_msg(input logic [607:0] hdr, input logic [31:0] n);
        return {hdr, n, 1'b1, 319'd0, 64'd640};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            job_ready    <= 1'b0;
            core_start   <= 1'b0;
            core_message <= '0;
            found_valid  <= 1'b0;
            found_nonce  <= '0;
            found_digest <= '0;
            exhausted    <= 1'b0;
            timeout_err  <= 1'b0;
            hash_count   <= '0;
            target_q     <= '0;
            digest_q     <= '0;
            nonce_end_q  <= '0;
            nonce_q      <= '0;
            watchdog     <= '0;
        end else begin
            core_start <= 1'b0;
            exhausted  <= 1'b0;

            if (abort && state != ST_IDLE) begin
                state       <= ST_IDLE;
                found_valid <= 1'b0;
                job_ready   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (job_valid && job_ready) begin
                            // Header is kept only inside core_message; it is
                            // reused from there when the nonce advances.
                            core_message <= build_msg(job_header, NONCE_START);
                            target_q     <= job_target;
                            nonce_end_q  <= job_nonce_end;
                            nonce_q      <= NONCE_START;
                            hash_count   <= '0;
                            job_ready    <= 1'b0;
                            state        <= ST_ISSUE;
                        end else begin
                            job_ready <= 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        core_start <= 1'b1;
                        watchdog   <= '0;
                        state      <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (core_done) begin
                            digest_q   <= core_digest;
                            hash_count <= hash_count + 32'd1;
                            state      <= ST_CHECK;
                        end else if (watchdog == WD_LAST) begin
                            timeout_err <= 1'b1;
                            job_ready   <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            watchdog <= watchdog + 32'd1;
                        end
                    end
                    ST_CHECK: begin
                        state <= (digest_q <= target_q) ? ST_REPORT : ST_NEXT;
                    end
                    ST_REPORT: begin
                        // First REPORT cycle raises the flag; an ack only
                        // counts once the host can actually see it.
                        if (!found_valid) begin
                            found_valid  <= 1'b1;
                            found_nonce  <= nonce_q;
                            found_digest <= digest_q;
                        end else if (found_ack) begin
                            found_valid <= 1'b0;
                            state       <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (nonce_rem < NONCE_STEP) begin
                            exhausted <= 1'b1;
                            job_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            nonce_q      <= nonce_nxt;
                            core_message <= build_msg(core_message[1023:416], nonce_nxt);
                            state        <= ST_ISSUE;
                        end
                    end
                    default: begin
                        job_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// tb/tb_sha_nonce_scheduler.sv - directed self-checking bench for sha_nonce_scheduler
module tb_sha_nonce_scheduler;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [607:0]  job_header;
    logic [255:0]  job_target;
    logic [31:0]   job_nonce_end;
    logic [255:0]  core_digest;

    logic          job_valid   [3];
    logic          abort       [3];
    logic          core_done   [3];
    logic          found_ack   [3];
    logic          job_ready   [3];
    logic          core_start  [3];
    logic          found_valid [3];
    logic          exhausted   [3];
    logic          timeout_err [3];
    logic [1023:0] core_message [3];
    logic [31:0]   found_nonce  [3];
    logic [255:0]  found_digest [3];
    logic [31:0]   hash_count   [3];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Instance 0: start 5; instance 1: start 0x12345678; instance 2: start 0xFFFFFFFE.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        sha_nonce_scheduler #(
            .NONCE_START    (g == 0 ? 32'd5 : (g == 1 ? 32'h12345678 : 32'hFFFFFFFE)),
            .NONCE_STEP     (32'd1),
            .TIMEOUT_CYCLES (16)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .job_valid     (job_valid[g]),
            .job_ready     (job_ready[g]),
            .job_header    (job_header),
            .job_target    (job_target),
            .job_nonce_end (job_nonce_end),
            .abort         (abort[g]),
            .core_start    (core_start[g]),
            .core_message  (core_message[g]),
            .core_done     (core_done[g]),
            .core_digest   (core_digest),
            .found_valid   (found_valid[g]),
            .found_nonce   (found_nonce[g]),
            .found_digest  (found_digest[g]),
            .found_ack     (found_ack[g]),
            .exhausted     (exhausted[g]),
            .timeout_err   (timeout_err[g]),
            .hash_count    (hash_count[g])
        );
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int i);
        for (int k = 0; k < 20 && core_start[i] !== 1'b1; k++) step();
        chk("start_seen", core_start[i], 1);
    endtask

    task automatic offer_job(input int i, input logic [255:0] tgt, input logic [31:0] nend);
        job_target    = tgt;
        job_nonce_end = nend;
        job_valid[i]  = 1'b1;
        step();
        job_valid[i]  = 1'b0;
        chk("accept_ready_low", job_ready[i], 0);
    endtask

    // Plays the core for one hash; on a hit, checks the report and acks it.
    task automatic run_hash(input int i, input logic [255:0] dig, input logic [31:0] n, input bit hit);
        wait_start(i);
        chk("msg_nonce", core_message[i][415:384], n);
        step();
        chk("start_one_cycle", core_start[i], 0);
        core_digest  = dig;
        core_done[i] = 1'b1;
        step();
        core_done[i] = 1'b0;
        step();
        chk("found_not_early", found_valid[i], 0);
        if (hit) begin
            step();
            chk("found_valid", found_valid[i], 1);
            chk("found_nonce", found_nonce[i], n);
            chk("found_digest", found_digest[i], dig);
            found_ack[i] = 1'b1;
            step();
            found_ack[i] = 1'b0;
            chk("found_cleared", found_valid[i], 0);
        end
    endtask

    initial begin
        logic [607:0] hdr_a5;
        for (int i = 0; i < 3; i++) begin
            job_valid[i] = 1'b0;
            abort[i]     = 1'b0;
            core_done[i] = 1'b0;
            found_ack[i] = 1'b0;
        end
        hdr_a5        = {76{8'hA5}};
        job_header    = {19{32'hC0DE0001}};
        job_target    = '0;
        job_nonce_end = '0;
        core_digest   = '0;

        // Reset state
        step();
        step();
        chk("rst_job_ready", job_ready[0], 0);
        chk("rst_core_start", core_start[0], 0);
        chk("rst_found_valid", found_valid[0], 0);
        chk("rst_hash_count", hash_count[0], 0);
        chk("rst_core_message", core_message[0][319:0], 0);
        rst = 1'b1;
        step();
        chk("ready_after_rst", job_ready[0], 1);

        // 1: range 5..7, every digest hits
        offer_job(0, {256{1'b1}}, 32'd7);
        chk("issue_latency", core_start[0], 0);
        run_hash(0, 256'hAAAA, 32'd5, 1'b1);
        run_hash(0, 256'hBBBB, 32'd6, 1'b1);
        run_hash(0, 256'hCCCC, 32'd7, 1'b1);
        step();
        chk("t1_exhausted", exhausted[0], 1);
        chk("t1_hash_count", hash_count[0], 3);
        chk("t1_ready", job_ready[0], 1);
        step();
        chk("t1_exhausted_pulse", exhausted[0], 0);

        // 2: no hit, 4 hashes
        offer_job(0, 256'd0, 32'd8);
        for (int n = 5; n <= 8; n++) run_hash(0, 256'h1000 + 256'(n), 32'(n), 1'b0);
        step();
        chk("t2_exhausted", exhausted[0], 1);
        chk("t2_ready", job_ready[0], 1);
        chk("t2_hash_count", hash_count[0], 4);
        chk("t2_no_found", found_valid[0], 0);
        step();
        chk("t2_no_extra_start", core_start[0], 0);

        // 3: message format, single-hash range
        job_header = hdr_a5;
        offer_job(1, 256'd0, 32'h12345678);
        wait_start(1);
        chk("t3_nonce", core_message[1][415:384], 32'h12345678);
        chk("t3_pad", core_message[1][383], 1);
        chk("t3_zero", core_message[1][382:64], 0);
        chk("t3_len", core_message[1][63:0], 640);
        chk("t3_header", core_message[1][1023:416] === hdr_a5, 1);
        run_hash(1, 256'd1, 32'h12345678, 1'b0);
        step();
        chk("t3_one_hash_exhausted", exhausted[1], 1);
        chk("t3_hash_count", hash_count[1], 1);

        // 4: timeout
        offer_job(0, 256'd0, 32'd1000);
        wait_start(0);
        for (int k = 0; k < 15; k++) step();
        chk("t4_no_early_timeout", timeout_err[0], 0);
        chk("t4_still_busy", job_ready[0], 0);
        step();
        chk("t4_timeout_err", timeout_err[0], 1);
        chk("t4_idle", job_ready[0], 1);
        core_digest  = 256'd7;
        core_done[0] = 1'b1;
        step();
        core_done[0] = 1'b0;
        step();
        chk("t4_late_done_ignored", hash_count[0], 0);
        chk("t4_late_no_found", found_valid[0], 0);

        // 5: abort in REPORT with found_ack in the same cycle
        offer_job(0, {256{1'b1}}, 32'd100);
        wait_start(0);
        step();
        core_digest  = 256'h55;
        core_done[0] = 1'b1;
        step();
        core_done[0] = 1'b0;
        step();
        step();
        chk("t5_in_report", found_valid[0], 1);
        abort[0]     = 1'b1;
        found_ack[0] = 1'b1;
        step();
        abort[0]     = 1'b0;
        found_ack[0] = 1'b0;
        chk("t5_found_dropped", found_valid[0], 0);
        chk("t5_idle", job_ready[0], 1);
        chk("t5_no_exhausted", exhausted[0], 0);
        step();
        chk("t5_no_exhausted_later", exhausted[0], 0);
        chk("t5_no_restart", core_start[0], 0);
        chk("t5_timeout_sticky", timeout_err[0], 1);

        // 6: wrap through 0xFFFFFFFF
        offer_job(2, 256'd0, 32'd1);
        run_hash(2, 256'h9, 32'hFFFFFFFE, 1'b0);
        run_hash(2, 256'h9, 32'hFFFFFFFF, 1'b0);
        run_hash(2, 256'h9, 32'h00000000, 1'b0);
        run_hash(2, 256'h9, 32'h00000001, 1'b0);
        step();
        chk("t6_exhausted", exhausted[2], 1);
        chk("t6_hash_count", hash_count[2], 4);

        // 6b: reset mid-WAIT clears outputs without a clock edge
        offer_job(2, 256'd0, 32'd1);
        wait_start(2);
        step();
        rst = 1'b0;
        #1;
        chk("rst_async_job_ready", job_ready[2], 0);
        chk("rst_async_message", core_message[2][319:0], 0);
        chk("rst_async_timeout", timeout_err[0], 0);
        chk("rst_async_hash_count", hash_count[2], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
